// File: rtl/angle_msg_tx_pkg.sv
// rtl/angle_msg_tx_pkg.sv - shared widths, state encoding and byte helpers for angle_msg_tx
// Purpose: common definitions for the angle message framer and its counter.
// Ports: none (package).
package angle_msg_tx_pkg;

  localparam int MSG_W   = 16;
  localparam int ANGLE_W = 12;
  localparam int SEQ_W   = 4;
  localparam int BYTE_W  = 8;
  localparam int CNT_W   = 16;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_SEND_HI,
    ST_WAIT_HI_RISE,
    ST_WAIT_HI_FALL,
    ST_GAP,
    ST_SEND_LO,
    ST_WAIT_LO_RISE,
    ST_WAIT_LO_FALL
  } state_e;

  // Sequence number rides in the bits above the angle field.
  function automatic logic [MSG_W-1:0] stamp_seq(input logic [MSG_W-1:0] msg,
                                                 input logic [SEQ_W-1:0] seq);
    return {seq, msg[ANGLE_W-1:0]};
  endfunction

  // High byte goes on the wire first.
  function automatic logic [BYTE_W-1:0] hi_byte(input logic [MSG_W-1:0] w);
    return w[MSG_W-1 -: BYTE_W];
  endfunction

  function automatic logic [BYTE_W-1:0] lo_byte(input logic [MSG_W-1:0] w);
    return w[BYTE_W-1:0];
  endfunction

endpackage

// File: rtl/angle_msg_tx_if.sv
// rtl/angle_msg_tx_if.sv - message source and uart_tx side signals of angle_msg_tx
// Purpose: bundles the message handshake, the uart_tx control pair and status pulses.
// Ports: none; modport slave is the framer, modport master is the source/uart side.
interface angle_msg_tx_if;
  import angle_msg_tx_pkg::*;

  logic [MSG_W-1:0]  msg;
  logic              msg_valid;
  logic              msg_ready;
  logic              start_tx;
  logic [BYTE_W-1:0] data_to_tx;
  logic              tx_busy;
  logic              done;
  logic              err_timeout;
  logic [SEQ_W-1:0]  seq;

  modport slave (
    input  msg, msg_valid, tx_busy,
    output msg_ready, start_tx, data_to_tx, done, err_timeout, seq
  );

  modport master (
    output msg, msg_valid, tx_busy,
    input  msg_ready, start_tx, data_to_tx, done, err_timeout, seq
  );

endinterface

// File: rtl/angle_msg_tx_cycle_counter.sv
// rtl/angle_msg_tx_cycle_counter.sv - 16-bit clear/enable counter with terminal flag
// Purpose: shared timer for the inter-byte gap and both busy-rise timeouts.
// Ports: clk, reset (async active-low), clr_i (zero the count), en_i (count up),
//        target_i (terminal value), tc_o (count equals target).
module angle_msg_tx_cycle_counter
  import angle_msg_tx_pkg::*;
(
  input  logic             clk,
  input  logic             reset,
  input  logic             clr_i,
  input  logic             en_i,
  input  logic [CNT_W-1:0] target_i,
  output logic             tc_o
);

  logic [CNT_W-1:0] count_q, count_d;

  assign tc_o = (count_q == target_i);

  // Holds at the terminal value so a late enable cannot wrap it.
  always_comb begin
    count_d = count_q;
    if (clr_i) begin
      count_d = '0;
    end else if (en_i && !tc_o) begin
      count_d = count_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

endmodule

// File: rtl/angle_msg_tx.sv
// rtl/angle_msg_tx.sv - frames a 16-bit angle message as two uart_tx bytes with an idle gap
// Purpose: accepts a message, sends high then low byte through uart_tx, stamps sequence.
// Ports: clk, reset (async active-low), bus (slave modport: msg/msg_valid/msg_ready,
//        start_tx/data_to_tx/tx_busy, done, err_timeout, seq).
module angle_msg_tx
  import angle_msg_tx_pkg::*;
#(
  parameter int unsigned GAP_CYCLES   = 24,
  parameter int unsigned BUSY_TIMEOUT = 64,
  parameter bit          SEQ_EN       = 1'b1
) (
  input  logic          clk,
  input  logic          reset,
  angle_msg_tx_if.slave bus
);

  // The counter is cleared on the transition into a waiting state, so it reads 0 in the
  // first waiting cycle; targets are pulled in to account for that and for the output
  // register that follows the decision.
  localparam logic [CNT_W-1:0] GAP_TGT = CNT_W'(GAP_CYCLES - 1);
  localparam logic [CNT_W-1:0] TO_TGT  = CNT_W'(BUSY_TIMEOUT - 2);

  state_e            state_q, state_d;
  logic [MSG_W-1:0]  word_q, word_d;
  logic [BYTE_W-1:0] data_q, data_d;
  logic [SEQ_W-1:0]  seq_q, seq_d;
  logic              start_q, start_d;
  logic              ready_q, ready_d;
  logic              done_q, done_d;
  logic              err_q, err_d;
  logic              cnt_clr, cnt_en, cnt_tc;
  logic [CNT_W-1:0]  cnt_tgt;

  angle_msg_tx_cycle_counter u_cnt (
    .clk      (clk),
    .reset    (reset),
    .clr_i    (cnt_clr),
    .en_i     (cnt_en),
    .target_i (cnt_tgt),
    .tc_o     (cnt_tc)
  );

  // start_tx is registered, so the pulse is decided one cycle ahead: a SEND state is
  // entered with the pulse already up when uart_tx was idle, otherwise the SEND state
  // keeps polling tx_busy and raises the pulse itself before moving on.
  always_comb begin
    state_d = state_q;
    word_d  = word_q;
    data_d  = data_q;
    seq_d   = seq_q;
    start_d = 1'b0;
    done_d  = 1'b0;
    err_d   = 1'b0;
    cnt_clr = 1'b0;
    cnt_en  = 1'b0;
    cnt_tgt = GAP_TGT;
    case (state_q)
      ST_IDLE: begin
        if (bus.msg_valid && ready_q) begin
          word_d  = SEQ_EN ? stamp_seq(bus.msg, seq_q) : bus.msg;
          data_d  = hi_byte(word_d);
          start_d = !bus.tx_busy;
          state_d = ST_SEND_HI;
        end
      end
      ST_SEND_HI: begin
        if (start_q) begin
          cnt_clr = 1'b1;
          state_d = ST_WAIT_HI_RISE;
        end else begin
          start_d = !bus.tx_busy;
        end
      end
      ST_WAIT_HI_RISE: begin
        cnt_tgt = TO_TGT;
        if (bus.tx_busy) begin
          state_d = ST_WAIT_HI_FALL;
        end else if (cnt_tc) begin
          err_d   = 1'b1;
          state_d = ST_IDLE;
        end else begin
          cnt_en = 1'b1;
        end
      end
      ST_WAIT_HI_FALL: begin
        if (!bus.tx_busy) begin
          cnt_clr = 1'b1;
          state_d = ST_GAP;
        end
      end
      ST_GAP: begin
        if (cnt_tc) begin
          data_d  = lo_byte(word_q);
          start_d = !bus.tx_busy;
          state_d = ST_SEND_LO;
        end else begin
          cnt_en = 1'b1;
        end
      end
      ST_SEND_LO: begin
        if (start_q) begin
          cnt_clr = 1'b1;
          state_d = ST_WAIT_LO_RISE;
        end else begin
          start_d = !bus.tx_busy;
        end
      end
      ST_WAIT_LO_RISE: begin
        cnt_tgt = TO_TGT;
        if (bus.tx_busy) begin
          state_d = ST_WAIT_LO_FALL;
        end else if (cnt_tc) begin
          err_d   = 1'b1;
          state_d = ST_IDLE;
        end else begin
          cnt_en = 1'b1;
        end
      end
      ST_WAIT_LO_FALL: begin
        if (!bus.tx_busy) begin
          done_d  = 1'b1;
          seq_d   = seq_q + SEQ_W'(1);
          state_d = ST_IDLE;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
    ready_d = (state_d == ST_IDLE);
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= ST_IDLE;
      word_q  <= '0;
      data_q  <= '0;
      seq_q   <= '0;
      start_q <= 1'b0;
      ready_q <= 1'b1;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      word_q  <= word_d;
      data_q  <= data_d;
      seq_q   <= seq_d;
      start_q <= start_d;
      ready_q <= ready_d;
      done_q  <= done_d;
      err_q   <= err_d;
    end
  end

  assign bus.msg_ready   = ready_q;
  assign bus.start_tx    = start_q;
  assign bus.data_to_tx  = data_q;
  assign bus.done        = done_q;
  assign bus.err_timeout = err_q;
  assign bus.seq         = seq_q;

endmodule
